sbus_mem_req: RTL
=================

Name: sbus_mem_req

Overview:
- Downstream consumer of the physical memory address stage.
- Captures a physical address (PA 14:35), its address parity and the cycle type on request.
- Runs the SBUS memory handshake: start, address acknowledge, one to four data-valid returns (wrapping within the quadword), or an NXM timeout.
- Reports busy, done and error status back to the MBOX cycle control.

Parameters:
- ACK_TIMEOUT, 64: clocks to wait in ADR_WAIT/DATA_WAIT before declaring NXM. Minimum 2; counter width is clog2(ACK_TIMEOUT+1).
- CHECK_PAR, 1: when 1, bad address parity aborts the cycle with par_err. When 0, parity is ignored.

Ports:
- clock  in  1  Single MBOX clock (CLK.PMA domain). All state changes on its rising edge.
- reset_n  in  1  Reset, asynchronous, active-low.
- req  in  1  Cycle request. Accepted only in IDLE.
- pa  in  22  Physical address PA[14:35]. Bits [34:35] are the word within the quadword.
- adr_par  in  1  Odd parity over pa[14:33], as the PMA stage generates it.
- rd  in  1  Read cycle (sampled with req).
- wr  in  1  Write cycle (sampled with req). rd and wr both 1 means read-pause-write.
- quad  in  1  1 = four-word cycle, 0 = single word.
- mem_adr_ack  in  1  SBUS address acknowledge.
- mem_data_valid  in  1  One word returned or taken by memory.
- sbus_start  out  1  SBUS start, held from START until ack.
- sbus_adr  out  22  Latched address, with [34:35] = current word.
- sbus_rq  out  4  Word request mask, bit i = word i of the quadword.
- sbus_rd  out  1  Latched rd.
- sbus_wr  out  1  Latched wr.
- busy  out  1  Not IDLE.
- word_idx  out  2  Current word pointer.
- done  out  1  One-clock pulse on normal completion.
- nxm  out  1  One-clock pulse on timeout.
- par_err  out  1  One-clock pulse on address parity failure.

Behaviour:
- Reset: state IDLE. All outputs 0; latched address, mask and timer cleared. Asynchronous reset mid-cycle abandons the cycle immediately; no done, nxm or par_err pulse is produced.
- IDLE:
  - req=1 with rd|wr=1: latch pa, rd, wr, quad; word_idx <= pa[34:35].
  - Parity check: if CHECK_PAR and ^{pa[14:33],adr_par} != 1, go to ERR_PAR. Otherwise go to START.
  - req with rd=wr=0 is ignored.
- sbus_rq mask:
  - quad=1: 4'b1111.
  - quad=0: one-hot of pa[34:35], with bit 0 = word 0.
- START: assert sbus_start; clear the timer; go to ADR_WAIT. Next accept is no earlier than 1 clock after done/nxm/par_err.
- ADR_WAIT: sbus_start stays 1.
  - mem_adr_ack: drop sbus_start, clear the timer, go to DATA_WAIT.
  - Otherwise the timer increments. When timer == ACK_TIMEOUT-1 without ack, go to ERR_NXM.
- DATA_WAIT, on each mem_data_valid:
  - Clear that word's bit in sbus_rq.
  - word_idx <= word_idx+1 mod 4, so the sequence wraps within the quadword (start 2 gives 2,3,0,1).
  - Clear the timer.
  - If that was the last set bit, go to DONE.
- Simultaneous timer expiry and mem_data_valid: data wins; the word is accepted and the timer clears.
- mem_data_valid outside DATA_WAIT is ignored. mem_adr_ack outside ADR_WAIT is ignored.
- DONE: done=1 for one clock; busy=0 next clock; go to IDLE.
- ERR_NXM: nxm=1 for one clock; sbus_start=0; sbus_rq cleared; go to IDLE.
- ERR_PAR: par_err=1 for one clock; sbus_start is never asserted; go to IDLE.
- sbus_adr[14:33] is constant from latch to return to IDLE. sbus_adr[34:35] tracks word_idx.
- Latency, with ack and data immediately available:
  - req to sbus_start: 1 clock.
  - Single-word cycle, req to done: 4 clocks minimum.
- busy=1 from the clock after the req accept through the DONE/ERR state.

Test Plan:
- Single read, pa=22'h0ABC_D1 (word 1), quad=0, good parity; ack 2 clocks after start; data 1 clock later -> sbus_rq=4'b0010, sbus_adr=pa, done pulses once, busy drops the next clock.
- Quad read with pa[34:35]=2 and four data_valid pulses -> word_idx sequence 2,3,0,1; sbus_rq goes 1111→1011→0011→0010→0000; done after the fourth pulse.
- No ack, ACK_TIMEOUT=64 -> nxm pulses exactly 64 clocks after sbus_start rose; sbus_start=0 and busy=0 afterwards; no done.
- Bad adr_par with CHECK_PAR=1 -> par_err one clock after req; sbus_start never 1. Same stimulus with CHECK_PAR=0 -> normal cycle.
- Timer expiry coincident with the final mem_data_valid -> done, not nxm. req while busy -> ignored; latched pa unchanged.
- reset_n low during DATA_WAIT of a quad cycle -> all outputs 0 asynchronously, before the next clock edge; after release a new req runs normally.

Source files
------------

// File: rtl/sbus_mem_req.sv
`default_nettype none
// ============================================================================
// Module   : sbus_mem_req
// Brief    : SBUS memory request sequencer. It latches the address, checks
//            parity, runs the ack/data handshake and detects the NXM timeout.
// Revision : 1.0 - initial release
// ============================================================================
module sbus_mem_req #(
  parameter int ACK_TIMEOUT = 64,
  parameter bit CHECK_PAR   = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req,
  input  logic [21:0] pa,
  input  logic        adr_par,
  input  logic        rd,
  input  logic        wr,
  input  logic        quad,
  input  logic        mem_adr_ack,
  input  logic        mem_data_valid,
  output logic        sbus_start,
  output logic [21:0] sbus_adr,
  output logic [3:0]  sbus_rq,
  output logic        sbus_rd,
  output logic        sbus_wr,
  output logic        busy,
  output logic [1:0]  word_idx,
  output logic        done,
  output logic        nxm,
  output logic        par_err
);

  // pa[21:2] carries PA[14:33]; pa[1:0] carries PA[34:35], the word in the quadword.
  localparam int                   c_timer_w    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [c_timer_w-1:0] c_timer_last = c_timer_w'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_ADR_WAIT  = 3'd2,
    S_DATA_WAIT = 3'd3,
    S_DONE      = 3'd4,
    S_ERR_NXM   = 3'd5,
    S_ERR_PAR   = 3'd6
  } state_t;

  state_t               r_state;
  logic [c_timer_w-1:0] r_timer;
  logic [19:0]          r_adr_hi;
  logic [1:0]           r_word;
  logic [3:0]           r_rq;
  logic                 r_rd;
  logic                 r_wr;
  logic                 r_start;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_nxm;
  logic                 r_par_err;

  logic                 w_par_ok;
  logic                 w_expire;
  logic [3:0]           w_first_bit;
  logic [3:0]           w_rq_left;
  logic [c_timer_w-1:0] w_timer_inc;

  assign w_par_ok    = !CHECK_PAR || (^{pa[21:2], adr_par});
  assign w_expire    = (r_timer == c_timer_last);
  assign w_first_bit = 4'b0001 << pa[1:0];
  assign w_rq_left   = r_rq & ~(4'b0001 << r_word);
  assign w_timer_inc = r_timer + c_timer_w'(1);

  // The timer counts clocks since sbus_start rose, so START already counts one.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_adr_hi  <= '0;
      r_word    <= '0;
      r_rq      <= '0;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      r_start   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_nxm     <= 1'b0;
      r_par_err <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_nxm     <= 1'b0;
      r_par_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req && (rd || wr)) begin
            r_adr_hi <= pa[21:2];
            r_word   <= pa[1:0];
            r_rd     <= rd;
            r_wr     <= wr;
            r_busy   <= 1'b1;
            r_timer  <= '0;
            if (w_par_ok) begin
              r_rq    <= quad ? 4'b1111 : w_first_bit;
              r_start <= 1'b1;
              r_state <= S_START;
            end else begin
              r_rq      <= '0;
              r_par_err <= 1'b1;
              r_state   <= S_ERR_PAR;
            end
          end
        end
        S_START: begin
          r_timer <= w_timer_inc;
          r_state <= S_ADR_WAIT;
        end
        S_ADR_WAIT: begin
          if (mem_adr_ack) begin
            r_start <= 1'b0;
            r_timer <= '0;
            r_state <= S_DATA_WAIT;
          end else if (w_expire) begin
            r_start <= 1'b0;
            r_rq    <= '0;
            r_nxm   <= 1'b1;
            r_state <= S_ERR_NXM;
          end else begin
            r_timer <= w_timer_inc;
          end
        end
        S_DATA_WAIT: begin
          // Data takes priority over a coincident timer expiry.
          if (mem_data_valid) begin
            r_rq    <= w_rq_left;
            r_word  <= r_word + 2'd1;
            r_timer <= '0;
            if (w_rq_left == 4'b0000) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end else if (w_expire) begin
            r_rq    <= '0;
            r_nxm   <= 1'b1;
            r_state <= S_ERR_NXM;
          end else begin
            r_timer <= w_timer_inc;
          end
        end
        S_DONE, S_ERR_NXM, S_ERR_PAR: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_start <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign sbus_start = r_start;
  assign sbus_adr   = {r_adr_hi, r_word};
  assign sbus_rq    = r_rq;
  assign sbus_rd    = r_rd;
  assign sbus_wr    = r_wr;
  assign busy       = r_busy;
  assign word_idx   = r_word;
  assign done       = r_done;
  assign nxm        = r_nxm;
  assign par_err    = r_par_err;

endmodule
`default_nettype wire
